// File: rtl/nibble_serial_alu_sequencer.sv
// Nibble-serial sequencer for a shared 4-bit add slice.
// Walks WIDTH-bit operands through the external slice one nibble per cycle,
// least-significant nibble first, keeping the inter-nibble carry locally.
module nibble_serial_alu_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 alu_sel0,
  output logic                 alu_sel1,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_cin,
  input  logic [3:0]           alu_d,
  input  logic                 alu_cout
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [1:0]      op_l;
  logic            cin_l;
  logic            accept;

  // A request is taken only when no operation is in flight (IDLE or DONE).
  assign accept = start && (state == IDLE || state == DONE);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control FSM plus the result/carry registers it owns; reset clears them all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= alu_d;
          carry                     <= alu_cout;
          if (idx == LAST_IDX) begin
            cout  <= alu_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (accept) begin
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture; later changes on a/b/op/cin cannot disturb a running op.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      a_l   <= a;
      b_l   <= b;
      op_l  <= op;
      cin_l <= cin;
    end
  end

  // Slice drive: current nibble and carry in RUN, all zero otherwise.
  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_cin  = 1'b0;
    alu_sel0 = 1'b0;
    alu_sel1 = 1'b0;
    if (state == RUN) begin
      alu_a    = a_l[{idx, 2'b00} +: 4];
      alu_b    = b_l[{idx, 2'b00} +: 4];
      alu_cin  = (idx == '0) ? cin_l : carry;
      alu_sel0 = op_l[0];
      alu_sel1 = op_l[1];
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_sequencer.sv
// Directed bench for nibble_serial_alu_sequencer with a behavioural 4-bit slice.
module tb_nibble_serial_alu_sequencer;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;
  logic             alu_sel0, alu_sel1, alu_cin, alu_cout;
  logic [3:0]       alu_a, alu_b, alu_d;

  int n_cmp  = 0;
  int n_fail = 0;

  // Operands as the DUT should have latched them.
  logic [1:0]       l_op;
  logic [WIDTH-1:0] l_a, l_b;
  logic             l_cin;

  always #5 clk = ~clk;

  nibble_serial_alu_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_sel0(alu_sel0), .alu_sel1(alu_sel1), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_d(alu_d), .alu_cout(alu_cout)
  );

  function automatic logic [3:0] bsel(input logic [1:0] s, input logic [3:0] bn);
    case (s)
      2'b00:   return bn;
      2'b01:   return ~bn;
      2'b10:   return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  // Behavioural slice: mux-selected B into a 4-bit adder.
  assign {alu_cout, alu_d} = {1'b0, alu_a} + {1'b0, bsel({alu_sel1, alu_sel0}, alu_b)}
                             + {4'b0, alu_cin};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic c);
    op = o; a = av; b = bv; cin = c; start = 1'b1;
    l_op = o; l_a = av; l_b = bv; l_cin = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Checks every RUN cycle and the DONE cycle; returns sampled in DONE.
  task automatic run_checks(input string nm, input logic [WIDTH-1:0] er,
                            input logic ec, input bit disturb);
    logic c;
    logic [4:0] s;
    c = l_cin;
    for (int i = 0; i < NIBBLES; i++) begin
      @(negedge clk);
      chk({nm, " busy"}, 32'(busy), 32'd1);
      chk({nm, " done_low"}, 32'(done), 32'd0);
      chk({nm, " alu_sel"}, 32'({alu_sel1, alu_sel0}), 32'(l_op));
      chk({nm, " alu_a"}, 32'(alu_a), 32'(l_a[4*i +: 4]));
      chk({nm, " alu_b"}, 32'(alu_b), 32'(l_b[4*i +: 4]));
      chk({nm, " alu_cin"}, 32'(alu_cin), 32'(c));
      s = {1'b0, l_a[4*i +: 4]} + {1'b0, bsel(l_op, l_b[4*i +: 4])} + {4'b0, c};
      c = s[4];
      if (disturb) begin
        a = 16'hFFFF; b = 16'hAAAA; op = 2'b11;
        start = (i < NIBBLES - 1);
      end
    end
    @(negedge clk);
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " busy_low"}, 32'(busy), 32'd0);
    chk({nm, " result"}, 32'(result), 32'(er));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
  endtask

  typedef struct {
    string            nm;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH-1:0] res;
    logic             cout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"add",       2'b00, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{"sub_neg",   2'b01, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
    vecs[2] = '{"sub_pos",   2'b01, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
    vecs[3] = '{"inc_wrap",  2'b10, 16'hFFFF, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{"dec_one",   2'b11, 16'h0001, 16'h1234, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{"dec_zero",  2'b11, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    vecs[6] = '{"add_wrap",  2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{"add_msb",   2'b00, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[8] = '{"pass_a",    2'b10, 16'h1234, 16'hFFFF, 1'b0, 16'h1234, 1'b0};

    rst = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst alu", 32'({alu_sel1, alu_sel0, alu_a, alu_b, alu_cin}), 32'd0);

    // Table-driven operations, each followed by an idle cycle.
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      run_checks(vecs[i].nm, vecs[i].res, vecs[i].cout, 1'b0);
      @(negedge clk);
      chk({vecs[i].nm, " done_pulse"}, 32'(done), 32'd0);
      chk({vecs[i].nm, " hold"}, 32'(result), 32'(vecs[i].res));
      chk({vecs[i].nm, " idle_alu"}, 32'({alu_sel1, alu_sel0, alu_a, alu_b, alu_cin}), 32'd0);
    end

    // start and operand changes during RUN are ignored.
    start_op(2'b00, 16'h1111, 16'h2222, 1'b0);
    run_checks("ignore", 16'h3333, 1'b0, 1'b1);

    // Back-to-back: start in DONE goes straight to RUN.
    start_op(2'b01, 16'h0100, 16'h0001, 1'b1);
    run_checks("b2b", 16'h00FF, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b idle", 32'(busy), 32'd0);

    // Reset in the third RUN cycle aborts with no done.
    start_op(2'b00, 16'h1234, 16'h0FFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort alu", 32'({alu_sel1, alu_sel0, alu_a, alu_b, alu_cin}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort no_done", 32'({busy, done}), 32'd0);
    end

    // rst and start together: request dropped.
    a = 16'h0F0F; b = 16'h0101; op = 2'b00; cin = 1'b0;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start idle", 32'({busy, done}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
